// File: rtl/burst_read_pipeline.sv
// Burst read engine: turns one {address, beats-1} request into a run of
// consecutive single-word memory reads against a fixed one-cycle-latency
// memory, buffers the returned words in a 4-entry FIFO and streams them out
// with valid/ready handshaking. A read is only issued when a FIFO slot is
// already reserved for its data, so the memory side never needs backpressure.
module burst_read_pipeline #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] u_addr,
    input  logic [7:0]            u_length,
    input  logic                  u_valid,
    output logic                  u_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_valid,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_valid,
    output logic                  d_last,
    input  logic                  d_ready
);

    localparam int         REM_W      = (MAX_BURST_LENGTH > 1) ? $clog2(MAX_BURST_LENGTH) : 1;
    localparam logic [7:0] LEN_CAP    = 8'(MAX_BURST_LENGTH - 1);
    localparam int         FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [REM_W-1:0]       remaining_q;
    logic                   inflight_q;
    logic                   last_dly_q;

    logic [DATA_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic                   fifo_last_q [FIFO_DEPTH];
    logic [1:0]             wr_ptr_q;
    logic [1:0]             rd_ptr_q;
    logic [2:0]             count_q;
    logic [2:0]             count_d;

    logic [7:0]             len_clamped;
    logic                   credit_ok;
    logic                   issue;
    logic                   last_beat;
    logic                   push;
    logic                   pop;

    // Oversized requests are clamped to the longest burst the counter can hold.
    assign len_clamped = (u_length > LEN_CAP) ? LEN_CAP : u_length;

    // Credit counts buffered words plus the read still on its way back;
    // a pop happening this cycle only frees credit from the next cycle on.
    assign credit_ok = ({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4;
    assign issue     = (state_q == BURST) && credit_ok;
    assign last_beat = (remaining_q == '0);
    // Data showing up with no read outstanding (e.g. from before a reset) is dropped.
    assign push      = mem_valid && inflight_q;
    assign pop       = (count_q != 3'd0) && d_ready;

    assign u_ready     = (state_q == IDLE);
    assign mem_read_en = issue;
    assign mem_addr    = addr_q;
    assign d_valid     = (count_q != 3'd0);
    assign d_data      = fifo_data_q[rd_ptr_q];
    assign d_last      = fifo_last_q[rd_ptr_q];

    // Issuer FSM: latch request, then walk the address until the last beat issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (u_valid) begin
                        addr_q      <= u_addr;
                        remaining_q <= REM_W'(len_clamped);
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        if (last_beat) begin
                            state_q <= IDLE;
                        end else begin
                            addr_q      <= addr_q + ADDR_WIDTH'(1);
                            remaining_q <= remaining_q - REM_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Track the single outstanding read and carry its last flag to the data cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            last_dly_q <= 1'b0;
        end else begin
            if (issue) begin
                inflight_q <= 1'b1;
                last_dly_q <= last_beat;
            end else if (push) begin
                inflight_q <= 1'b0;
            end
        end
    end

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Response FIFO storage and pointers; contents are wiped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_data;
                fifo_last_q[wr_ptr_q] <= last_dly_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_burst_read_pipeline.sv
// Scoreboard bench for burst_read_pipeline. Accepted requests are expanded
// into expected beats (address sequence, clamped length, last on final beat);
// a negedge monitor pops and compares every delivered beat and checks that
// stalled outputs hold. The memory returns its address as data one cycle later.
module tb_burst_read_pipeline;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] u_addr = '0;
    logic [7:0]  u_length = '0;
    logic        u_valid = 1'b0;
    logic        u_ready;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic [31:0] mem_data = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] d_data;
    logic        d_valid;
    logic        d_last;
    logic        d_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int ready_mode = 0;   // 0: held low, 1: always high, 2: random stalls

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    acc_cyc[$];

    logic        stall_pend = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    beat_t       mon_e;

    burst_read_pipeline #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MAX_BURST_LENGTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .u_addr(u_addr),
        .u_length(u_length),
        .u_valid(u_valid),
        .u_ready(u_ready),
        .mem_addr(mem_addr),
        .mem_read_en(mem_read_en),
        .mem_data(mem_data),
        .mem_valid(mem_valid),
        .d_data(d_data),
        .d_valid(d_valid),
        .d_last(d_last),
        .d_ready(d_ready)
    );

    always #5 clk = ~clk;

    // Cycle counter and one-cycle-latency memory returning addr as data.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_valid <= mem_read_en;
        mem_data  <= mem_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic chk_reset();
        chk("rst_u_ready", 32'(u_ready), 32'd1);
        chk("rst_mem_read_en", 32'(mem_read_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_d_data", d_data, 32'd0);
        chk("rst_d_last", 32'(d_last), 32'd0);
    endtask

    // Present a request, hold it until accepted, then queue its expected beats.
    task automatic send_req(input logic [31:0] a, input logic [7:0] len);
        int   guard;
        logic hs;
        int   nb;
        u_addr   = a;
        u_length = len;
        u_valid  = 1'b1;
        guard    = 0;
        hs       = 1'b0;
        while (!hs && guard < 200) begin
            @(negedge clk);
            hs = u_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("req_accepted", 32'(hs), 32'd1);
        u_valid  = 1'b0;
        u_addr   = $urandom;
        u_length = 8'($urandom);
        if (hs) begin
            nb = (len > 8'd3) ? 3 : int'(len);
            $display("req addr=%h len=%0d beats=%0d", a, len, nb + 1);
            for (int b = 0; b <= nb; b++)
                exp_q.push_back('{data: a + 32'(b), last: (b == nb)});
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Downstream ready driver.
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: d_ready = 1'b0;
                1: d_ready = 1'b1;
                default: begin
                    if (stall > 0) begin
                        d_ready = 1'b0;
                        stall--;
                    end else begin
                        d_ready = 1'b1;
                        if ($urandom_range(0, 2) == 0) stall = $urandom_range(1, 3);
                    end
                end
            endcase
        end
    end

    // Monitor: compare accepted beats against the scoreboard, check hold during stalls.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pend = 1'b0;
            end else begin
                if (mem_read_en) rd_cnt++;
                if (stall_pend) begin
                    chk("hold_valid", 32'(d_valid), 32'd1);
                    chk("hold_data", d_data, prev_data);
                    chk("hold_last", 32'(d_last), 32'(prev_last));
                end
                if (d_valid && d_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got data %h last %b, required no beat", d_data, d_last);
                    end else begin
                        mon_e = exp_q.pop_front();
                        $display("beat data=%h last=%b cycle=%0d", d_data, d_last, cyc);
                        chk("beat_data", d_data, mon_e.data);
                        chk("beat_last", 32'(d_last), 32'(mon_e.last));
                        acc_cyc.push_back(cyc);
                    end
                end
                stall_pend = d_valid && !d_ready;
                prev_data  = d_data;
                prev_last  = d_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, applied asynchronously.
        #2 rst_n = 1'b0;
        #1 chk_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;

        // Single beat and its latency.
        send_req(32'h10, 8'd0);
        @(negedge clk);
        chk("single_read_en", 32'(mem_read_en), 32'd1);
        chk("single_mem_addr", mem_addr, 32'h10);
        chk("single_valid_e0", 32'(d_valid), 32'd0);
        @(negedge clk);
        chk("single_valid_e1", 32'(d_valid), 32'd0);
        @(negedge clk);
        chk("single_valid_e2", 32'(d_valid), 32'd1);
        chk("single_data_e2", d_data, 32'h10);
        chk("single_last_e2", 32'(d_last), 32'd1);
        drain();

        // Three beats on consecutive cycles.
        acc_cyc.delete();
        send_req(32'h20, 8'd2);
        drain();
        chk("three_count", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("three_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            chk("three_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
        end

        // Clamp of an oversized length.
        send_req(32'h50, 8'd7);
        drain();

        // Credit limit while downstream is stalled.
        @(negedge clk);
        ready_mode = 0;
        @(posedge clk);
        #2;
        rd_cnt = 0;
        send_req(32'h40, 8'd3);
        send_req(32'h60, 8'd1);
        repeat (8) @(negedge clk);
        chk("credit_reads", 32'(rd_cnt), 32'd4);
        chk("credit_blocked", 32'(mem_read_en), 32'd0);
        chk("credit_valid", 32'(d_valid), 32'd1);
        ready_mode = 1;
        @(negedge clk);
        chk("credit_not_early", 32'(mem_read_en), 32'd0);
        @(negedge clk);
        chk("credit_resume", 32'(mem_read_en), 32'd1);
        chk("credit_resume_addr", mem_addr, 32'h60);
        drain();

        // Randomized bursts, gaps and stalls.
        ready_mode = 2;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_req(32'(i * 16), 8'($urandom_range(1, 3)));
        end
        drain();

        // Reset in the middle of a burst.
        ready_mode = 1;
        send_req(32'h70, 8'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1 chk_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_req(32'h80, 8'd2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
